// File: rtl/ysyx_25020047_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  ysyx_25020047_lsu : one-transaction-per-instruction load/store unit with
//  lane replication, byte strobes, load extension and misalignment trapping.
//  Rev 1.0
// ---------------------------------------------------------------------------
module ysyx_25020047_lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_addr,
  input  logic [DW-1:0]   in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_read,
  input  logic            in_write,
  input  logic [4:0]      in_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [DW-1:0]   mem_rsp_rdata,
  input  logic            mem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_rdata,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    funct3_q;
  logic [4:0]    rd_q;
  logic          read_q;
  logic          write_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          wen_q;

  logic accept;
  logic bad_align;
  logic illegal;
  logic no_op;

  assign accept = in_valid && in_ready;
  assign no_op  = !in_read && !in_write;

  // Unsupported widths fall into the misaligned bucket so they never reach memory.
  always_comb begin
    bad_align = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: bad_align = 1'b0;
      3'b001, 3'b101: bad_align = in_addr[0];
      3'b010:         bad_align = |in_addr[1:0];
      default:        bad_align = 1'b1;
    endcase
  end

  assign illegal = (in_read && in_write) || (!no_op && bad_align);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (illegal || no_op) ? DONE : REQ;
      REQ:  if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_rsp_valid) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [DW-1:0] rsp_shifted;
  logic [DW-1:0] load_ext;

  assign rsp_shifted = mem_rsp_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_ext = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b010:  load_ext = rsp_shifted;
      3'b100:  load_ext = {24'd0, rsp_shifted[7:0]};
      3'b101:  load_ext = {16'd0, rsp_shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        addr_q   <= in_addr;
        wdata_q  <= in_wdata;
        funct3_q <= in_funct3;
        rd_q     <= in_rd;
        read_q   <= in_read;
        write_q  <= in_write;
        rdata_q  <= '0;
        err_q    <= illegal;
        wen_q    <= 1'b0;
      end else if (state == WAIT && mem_rsp_valid) begin
        err_q   <= mem_rsp_err;
        wen_q   <= read_q && !mem_rsp_err;
        rdata_q <= (read_q && !mem_rsp_err) ? load_ext : '0;
      end
    end
  end

  logic [DW-1:0]   store_data;
  logic [DW/8-1:0] store_strb;

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        store_data = {4{wdata_q[7:0]}};
        store_strb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        store_data = {2{wdata_q[15:0]}};
        store_strb = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        store_data = wdata_q;
        store_strb = 4'b1111;
      end
    endcase
  end

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign mem_req_wen   = write_q;
  assign mem_req_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_req_wdata = store_data;
  assign mem_req_wstrb = write_q ? store_strb : '0;
  assign mem_rsp_ready = (state == WAIT);
  assign out_valid     = (state == DONE);
  assign out_rdata     = rdata_q;
  assign out_rd        = rd_q;
  assign out_wen       = wen_q;
  assign out_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  tb_ysyx_25020047_lsu : directed self-checking bench for the LSU.
//  Rev 1.0
// ---------------------------------------------------------------------------
module tb_ysyx_25020047_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_funct3;
  logic        in_read, in_write;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        out_valid, out_ready, out_wen, out_err;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25020047_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_read(in_read), .in_write(in_write), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_wen(out_wen), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge where out_valid is seen.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [4:0] rd,
                           input logic rd_en, input logic wr_en,
                           output int lat, output logic saw_req,
                           output logic [31:0] q_addr, output logic [31:0] q_wdata,
                           output logic [3:0] q_strb, output logic q_wen);
    in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_funct3 = f3;
    in_rd = rd; in_read = rd_en; in_write = wr_en;
    lat = 0; saw_req = 1'b0; q_addr = '0; q_wdata = '0; q_strb = '0; q_wen = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (mem_req_valid) begin
        saw_req = 1'b1; q_addr = mem_req_addr; q_wdata = mem_req_wdata;
        q_strb = mem_req_wstrb; q_wen = mem_req_wen;
      end
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("access_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("back_idle", {31'd0, in_ready}, 32'd1);
  endtask

  int          lat;
  logic        sreq, qwen;
  logic [31:0] qaddr, qwdata;
  logic [3:0]  qstrb;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
    in_read = 1'b0; in_write = 1'b0; in_rd = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
    check("rst_out_rdata", out_rdata, 32'd0);
    check("rst_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // lw aligned, zero-wait memory
    mem_rsp_rdata = 32'hDEADBEEF;
    do_access(32'h80000004, 32'h0, 3'b010, 5'd7, 1'b1, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("lw_lat", lat, 32'd3);
    check("lw_req_addr", qaddr, 32'h80000004);
    check("lw_req_strb", {28'd0, qstrb}, 32'd0);
    check("lw_req_wen", {31'd0, qwen}, 32'd0);
    check("lw_rdata", out_rdata, 32'hDEADBEEF);
    check("lw_wen", {31'd0, out_wen}, 32'd1);
    check("lw_err", {31'd0, out_err}, 32'd0);
    check("lw_rd", {27'd0, out_rd}, 32'd7);
    release_out();

    mem_rsp_rdata = 32'h80FF7F01;
    do_access(32'h80000003, 32'h0, 3'b000, 5'd1, 1'b1, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("lb_rdata", out_rdata, 32'hFFFFFF80);
    check("lb_req_addr", qaddr, 32'h80000000);
    release_out();
    do_access(32'h80000003, 32'h0, 3'b100, 5'd2, 1'b1, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("lbu_rdata", out_rdata, 32'h00000080);
    release_out();
    do_access(32'h80000002, 32'h0, 3'b001, 5'd3, 1'b1, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("lh_rdata", out_rdata, 32'hFFFF80FF);
    release_out();
    do_access(32'h80000000, 32'h0, 3'b101, 5'd4, 1'b1, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("lhu_rdata", out_rdata, 32'h00007F01);
    release_out();

    // stores
    do_access(32'h80000002, 32'h1234ABCD, 3'b001, 5'd0, 1'b0, 1'b1, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("sh_req_addr", qaddr, 32'h80000000);
    check("sh_req_strb", {28'd0, qstrb}, 32'h0000000C);
    check("sh_req_wdata", qwdata, 32'hABCDABCD);
    check("sh_req_wen", {31'd0, qwen}, 32'd1);
    check("sh_out_wen", {31'd0, out_wen}, 32'd0);
    check("sh_out_rdata", out_rdata, 32'd0);
    check("sh_out_err", {31'd0, out_err}, 32'd0);
    release_out();
    do_access(32'h80000001, 32'h000000A5, 3'b000, 5'd0, 1'b0, 1'b1, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("sb_req_strb", {28'd0, qstrb}, 32'h00000002);
    check("sb_req_wdata", qwdata, 32'hA5A5A5A5);
    release_out();

    // illegal / no-op paths never reach memory
    do_access(32'h80000002, 32'h0, 3'b010, 5'd5, 1'b1, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("mis_lat", lat, 32'd1);
    check("mis_req", {31'd0, sreq}, 32'd0);
    check("mis_err", {31'd0, out_err}, 32'd1);
    check("mis_wen", {31'd0, out_wen}, 32'd0);
    release_out();
    do_access(32'h80000001, 32'h0, 3'b001, 5'd5, 1'b0, 1'b1, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("mis_sh_req", {31'd0, sreq}, 32'd0);
    check("mis_sh_err", {31'd0, out_err}, 32'd1);
    release_out();
    do_access(32'h80000000, 32'h0, 3'b010, 5'd5, 1'b1, 1'b1, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("rw_lat", lat, 32'd1);
    check("rw_err", {31'd0, out_err}, 32'd1);
    release_out();
    do_access(32'h80000000, 32'h0, 3'b011, 5'd5, 1'b1, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("f3_bad_err", {31'd0, out_err}, 32'd1);
    check("f3_bad_req", {31'd0, sreq}, 32'd0);
    release_out();
    do_access(32'h80000000, 32'h0, 3'b010, 5'd5, 1'b0, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("nop_lat", lat, 32'd1);
    check("nop_err", {31'd0, out_err}, 32'd0);
    check("nop_wen", {31'd0, out_wen}, 32'd0);
    release_out();

    // memory fault
    mem_rsp_err = 1'b1;
    do_access(32'h80000008, 32'h0, 3'b010, 5'd9, 1'b1, 1'b0, lat, sreq, qaddr, qwdata, qstrb, qwen);
    check("rsperr_err", {31'd0, out_err}, 32'd1);
    check("rsperr_wen", {31'd0, out_wen}, 32'd0);
    check("rsperr_rdata", out_rdata, 32'd0);
    release_out();
    mem_rsp_err = 1'b0;

    // backpressure on both request and result sides
    mem_req_ready = 1'b0;
    in_valid = 1'b1; in_addr = 32'h80000008; in_wdata = 32'hCAFEF00D; in_funct3 = 3'b010;
    in_rd = 5'd0; in_read = 1'b0; in_write = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("stall_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("stall_req_addr", mem_req_addr, 32'h80000008);
      check("stall_req_wdata", mem_req_wdata, 32'hCAFEF00D);
      check("stall_req_strb", {28'd0, mem_req_wstrb}, 32'h0000000F);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    mem_req_ready = 1'b1;
    wait_out(lat);
    check("stall_lat", lat, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_out_err", {31'd0, out_err}, 32'd0);
      check("hold_out_wen", {31'd0, out_wen}, 32'd0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    mem_rsp_rdata = 32'h11223344;
    out_ready = 1'b1;
    in_valid = 1'b1; in_addr = 32'h80000004; in_funct3 = 3'b010; in_rd = 5'd12;
    in_read = 1'b1; in_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    check("b2b_no_req", {31'd0, mem_req_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("b2b_req_addr", mem_req_addr, 32'h80000004);
    wait_out(lat);
    check("b2b_rdata", out_rdata, 32'h11223344);
    check("b2b_rd", {27'd0, out_rd}, 32'd12);
    release_out();

    // asynchronous reset while waiting on a response
    mem_rsp_valid = 1'b0;
    in_valid = 1'b1; in_addr = 32'h80000010; in_funct3 = 3'b010; in_read = 1'b1; in_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("wait_rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_req_addr", mem_req_addr, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
